cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 118 +++++++++++
 tb/tb_cache_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Cache controller between the CPU memory stage, a direct-read cache and a 64-bit SRAM.
// Loads hit in the cache or fill a line from SRAM; stores are write-through, no-allocate.
module cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [16:0] cache_address,
    output logic [63:0] cache_wdata,
    output logic        cache_read_en,
    output logic        cache_write_en,
    output logic        cache_invoke_en,
    input  logic [31:0] cache_rdata,
    input  logic        cache_hit,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    typedef enum logic [1:0] {StIdle, StReadMiss, StWrite} state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] req_addr;
    logic [31:0] mapped;
    logic        offset;
    logic        unused_mapped_bits;

    // Live CPU address while idle, captured request once an access is in flight.
    assign req_addr           = (state_q == StIdle) ? address : addr_q;
    assign mapped             = req_addr - BASE_ADDR;
    assign offset             = mapped[2];
    assign cache_address      = mapped[18:2];
    assign unused_mapped_bits = ^{mapped[31:19], mapped[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (MEM_W_EN) begin
                        state_q <= StWrite;
                        addr_q  <= address;
                        wdata_q <= wdata;
                    end else if (MEM_R_EN && !cache_hit) begin
                        state_q <= StReadMiss;
                        addr_q  <= address;
                    end
                end
                StReadMiss: if (sram_ready) state_q <= StIdle;
                StWrite:    if (sram_ready) state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rdata           = 32'd0;
        ready           = 1'b1;
        cache_wdata     = 64'd0;
        cache_read_en   = 1'b0;
        cache_write_en  = 1'b0;
        cache_invoke_en = 1'b0;
        sram_address    = 32'd0;
        sram_wdata      = 32'd0;
        sram_r_en       = 1'b0;
        sram_w_en       = 1'b0;
        // Reset masks the live CPU inputs so no strobe escapes while rst is held.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (MEM_W_EN) begin
                        cache_invoke_en = 1'b1;
                        ready           = 1'b0;
                    end else if (MEM_R_EN) begin
                        if (cache_hit) begin
                            cache_read_en = 1'b1;
                            rdata         = cache_rdata;
                        end else begin
                            ready = 1'b0;
                        end
                    end
                end
                StReadMiss: begin
                    sram_r_en    = 1'b1;
                    sram_address = {addr_q[31:3], 3'b000};
                    ready        = sram_ready;
                    if (sram_ready) begin
                        cache_write_en = 1'b1;
                        cache_wdata    = sram_rdata;
                        rdata          = offset ? sram_rdata[63:32] : sram_rdata[31:0];
                    end
                end
                StWrite: begin
                    sram_w_en    = 1'b1;
                    sram_address = addr_q;
                    sram_wdata   = wdata_q;
                    ready        = sram_ready;
                end
                default: ready = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hit/miss loads, stores, simultaneous requests,
// reset in the middle of a miss and a long SRAM stall.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [16:0] cache_address;
    logic [63:0] cache_wdata;
    logic        cache_read_en;
    logic        cache_write_en;
    logic        cache_invoke_en;
    logic [31:0] cache_rdata;
    logic        cache_hit;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int errors = 0;
    int checks = 0;
    int stall  = 0;

    always #5 clk = ~clk;

    cache_controller #(.BASE_ADDR(32'd1024)) dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .wdata          (wdata),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .rdata          (rdata),
        .ready          (ready),
        .cache_address  (cache_address),
        .cache_wdata    (cache_wdata),
        .cache_read_en  (cache_read_en),
        .cache_write_en (cache_write_en),
        .cache_invoke_en(cache_invoke_en),
        .cache_rdata    (cache_rdata),
        .cache_hit      (cache_hit),
        .sram_address   (sram_address),
        .sram_wdata     (sram_wdata),
        .sram_r_en      (sram_r_en),
        .sram_w_en      (sram_w_en),
        .sram_rdata     (sram_rdata),
        .sram_ready     (sram_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe word {read, write, invoke, sram_r, sram_w, ready}
    function automatic logic [63:0] strobes();
        return 64'({cache_read_en, cache_write_en, cache_invoke_en, sram_r_en, sram_w_en, ready});
    endfunction

    initial begin
        rst         = 1'b1;
        address     = 32'h40C;
        wdata       = 32'h0;
        MEM_R_EN    = 1'b1;
        MEM_W_EN    = 1'b0;
        cache_rdata = 32'hDEADBEEF;
        cache_hit   = 1'b1;
        sram_rdata  = 64'h0;
        sram_ready  = 1'b0;
        #2;
        // Reset masks an otherwise-hitting load
        chk("rst_strobes", strobes(), 64'b000001);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_sram_addr", 64'(sram_address), 64'h0);
        chk("rst_sram_wdata", 64'(sram_wdata), 64'h0);
        MEM_R_EN = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("idle_strobes", strobes(), 64'b000001);

        // Read miss at 0x40C: mapped 0xC, word addr 3, offset 1
        address   = 32'h40C;
        MEM_R_EN  = 1'b1;
        cache_hit = 1'b0;
        #1;
        chk("miss_idle_strobes", strobes(), 64'b000000);
        chk("miss_cache_addr", 64'(cache_address), 64'h3);
        tick();
        address  = 32'h0000FFF0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b1;
        #1;
        chk("rm_strobes", strobes(), 64'b000100);
        chk("rm_sram_addr", 64'(sram_address), 64'h408);
        chk("rm_cache_addr", 64'(cache_address), 64'h3);
        sram_rdata = {32'hBBBB0000, 32'hAAAA0000};
        sram_ready = 1'b1;
        #1;
        chk("fill_strobes", strobes(), 64'b010101);
        chk("fill_wdata", cache_wdata, 64'hBBBB0000_AAAA0000);
        chk("fill_rdata", 64'(rdata), 64'hBBBB0000);
        tick();
        sram_ready  = 1'b0;
        MEM_W_EN    = 1'b0;
        address     = 32'h40C;
        MEM_R_EN    = 1'b1;
        cache_hit   = 1'b1;
        cache_rdata = 32'hBBBB0000;
        #1;
        chk("hit_strobes", strobes(), 64'b100001);
        chk("hit_rdata", 64'(rdata), 64'hBBBB0000);

        // Store at 0x410
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b1;
        address  = 32'h410;
        wdata    = 32'h12345678;
        #1;
        chk("st_idle_strobes", strobes(), 64'b001000);
        chk("st_cache_addr", 64'(cache_address), 64'h4);
        chk("st_idle_rdata", 64'(rdata), 64'h0);
        tick();
        MEM_W_EN = 1'b0;
        address  = 32'h0;
        wdata    = 32'hFFFFFFFF;
        #1;
        chk("wr_strobes", strobes(), 64'b000010);
        chk("wr_sram_addr", 64'(sram_address), 64'h410);
        chk("wr_sram_wdata", 64'(sram_wdata), 64'h12345678);
        chk("wr_cache_addr", 64'(cache_address), 64'h4);
        tick();
        chk("wr_hold_strobes", strobes(), 64'b000010);
        sram_ready = 1'b1;
        #1;
        chk("wr_done_strobes", strobes(), 64'b000011);
        tick();
        sram_ready = 1'b0;
        #1;
        chk("wr_back_idle", strobes(), 64'b000001);

        // Simultaneous load and store takes the write path
        MEM_R_EN  = 1'b1;
        MEM_W_EN  = 1'b1;
        cache_hit = 1'b1;
        address   = 32'h420;
        wdata     = 32'hCAFEF00D;
        #1;
        chk("both_idle_strobes", strobes(), 64'b001000);
        tick();
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        chk("both_wr_strobes", strobes(), 64'b000010);
        chk("both_sram_wdata", 64'(sram_wdata), 64'hCAFEF00D);
        sram_ready = 1'b1;
        #1;
        chk("both_done", strobes(), 64'b000011);
        tick();
        sram_ready = 1'b0;

        // Reset in the middle of a miss
        address   = 32'h40C;
        MEM_R_EN  = 1'b1;
        cache_hit = 1'b0;
        tick();
        MEM_R_EN = 1'b0;
        #1;
        chk("rstmid_pre", strobes(), 64'b000100);
        #2;
        rst        = 1'b1;
        sram_ready = 1'b1;
        #1;
        chk("rstmid_strobes", strobes(), 64'b000001);
        chk("rstmid_sram_addr", 64'(sram_address), 64'h0);
        chk("rstmid_rdata", 64'(rdata), 64'h0);
        tick();
        rst        = 1'b0;
        sram_ready = 1'b0;
        tick();
        chk("rstmid_after", strobes(), 64'b000001);

        // Miss at 0x500 (offset 0) with a 5-cycle SRAM stall
        address   = 32'h500;
        MEM_R_EN  = 1'b1;
        cache_hit = 1'b0;
        tick();
        MEM_R_EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ready === 1'b0) stall++;
            tick();
        end
        chk("stall_len", 64'(stall), 64'd5);
        sram_rdata = {32'h22222222, 32'h11111111};
        sram_ready = 1'b1;
        #1;
        chk("stall_done", strobes(), 64'b010101);
        chk("stall_rdata", 64'(rdata), 64'h11111111);
        tick();
        sram_ready = 1'b0;
        #1;
        chk("stall_idle", strobes(), 64'b000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
